fcvt_round_wb: RTL

//   Rounding and writeback stage directly downstream of the int->FP32 converter.

---
 rtl/fpu_pkg.sv | 34 +++
 rtl/fcvt_round_wb_if.sv | 32 +++
 rtl/fp_round_dec.sv | 23 ++
 rtl/fcvt_round_wb.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// FP32 constants, RISC-V rounding-mode encodings and fflags bit positions
// shared by the int->FP32 rounding/writeback stage.
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Magnitudes only; the sign bit is prepended at the use site.
    localparam logic [30:0] FP32_MAXNORM = 31'h7F7F_FFFF;
    localparam logic [30:0] FP32_INF     = 31'h7F80_0000;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  fflags;
    } wb_t;

    function automatic logic rm_illegal(input logic [2:0] rm);
        return rm > RM_RMM;
    endfunction

endpackage

// File: rtl/fcvt_round_wb_if.sv
// Converter-result input and FP register-file writeback handshake bundle.
// master = producer of converter results / consumer of writeback; slave = the stage.
interface fcvt_round_wb_if #(
    parameter int TAG_W = 5,
    parameter int SIG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [7:0]       in_exp;
    logic [SIG_W-1:0] in_sig;
    logic             in_zero;
    logic [2:0]       in_rm;
    logic [TAG_W-1:0] in_rd;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_rd;
    logic [4:0]       out_fflags;
    logic             out_illegal;

    modport master (
        output in_valid, in_sign, in_exp, in_sig, in_zero, in_rm, in_rd, out_ready,
        input  in_ready, out_valid, out_data, out_rd, out_fflags, out_illegal
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_sig, in_zero, in_rm, in_rd, out_ready,
        output in_ready, out_valid, out_data, out_rd, out_fflags, out_illegal
    );
endinterface

// File: rtl/fp_round_dec.sv
// Combinational round-up decision from rounding mode, sign and lsb/guard/sticky.
// Reserved encodings fall through to round-to-nearest-even.
module fp_round_dec
    import fpu_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    output logic       round_up
);
    always_comb begin
        round_up = guard & (sticky | lsb);
        case (rm)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = sign & (guard | sticky);
            RM_RUP:  round_up = !sign & (guard | sticky);
            RM_RMM:  round_up = guard;
            default: round_up = guard & (sticky | lsb);
        endcase
    end
endmodule

// File: rtl/fcvt_round_wb.sv
// FP32 rounding + writeback stage, 2-deep valid/ready pipeline after the int->FP converter.
// Optional sticky fflags accumulator enabled by defining FCVT_FFLAGS_ACC_EN.
module fcvt_round_wb
    import fpu_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int SIG_W = 32
) (
    input  logic           clk,
    input  logic           resetn,
`ifdef FCVT_FFLAGS_ACC_EN
    input  logic           fflags_clr,
    output logic [4:0]     fflags_acc,
`endif
    fcvt_round_wb_if.slave io
);
    logic             vld_p1, vld_p2;
    logic             ready_p1, ready_p2;
    logic [22:0]      mant_c;
    logic             guard_c, sticky_c, rup_c, illegal_c;
    logic [2:0]       rm_eff_c;

    logic             sign_p1, rup_p1, nx_p1, ill_p1, zero_p1;
    logic [7:0]       exp_p1;
    logic [22:0]      mant_p1;
    logic [2:0]       rm_p1;
    logic [TAG_W-1:0] rd_p1;

    logic [31:0]      data_p2;
    logic [4:0]       fflags_p2;
    logic [TAG_W-1:0] rd_p2;
    logic             ill_p2;
    wb_t              wb_c;

    function automatic wb_t round_pack(input logic sign, input logic [7:0] exp,
                                       input logic [22:0] mant, input logic rup,
                                       input logic nx, input logic [2:0] rm,
                                       input logic zero);
        logic [30:0] sum;
        logic        to_inf;
        wb_t         r;
        // One add over {exp,mant} lets a mantissa carry-out bump the exponent.
        sum    = {exp, mant} + {30'd0, rup};
        to_inf = (rm == RM_RNE) || (rm == RM_RMM) ||
                 (rm == RM_RUP && !sign) || (rm == RM_RDN && sign);
        r.data = {sign, sum};
        r.fflags = '0;
        r.fflags[FLAG_NX] = nx;
        if (zero) begin
            r.data   = {sign, 31'd0};
            r.fflags = '0;
        end else if (sum[30:23] == 8'hFF) begin
            r.data = {sign, to_inf ? FP32_INF : FP32_MAXNORM};
            r.fflags[FLAG_OF] = 1'b1;
            r.fflags[FLAG_NX] = 1'b1;
        end
        return r;
    endfunction

    assign ready_p2    = !vld_p2 || io.out_ready;
    assign ready_p1    = !vld_p1 || ready_p2;
    assign io.in_ready = ready_p1;

    assign mant_c    = io.in_sig[SIG_W-2 -: 23];
    assign guard_c   = io.in_sig[SIG_W-25];
    assign illegal_c = rm_illegal(io.in_rm);
    assign rm_eff_c  = illegal_c ? RM_RNE : io.in_rm;

    generate
        if (SIG_W > 25) begin : g_sticky
            assign sticky_c = |io.in_sig[SIG_W-26:0];
        end else begin : g_no_sticky
            assign sticky_c = 1'b0;
        end
    endgenerate

    fp_round_dec u_round_dec (
        .rm       (rm_eff_c),
        .sign     (io.in_sign),
        .lsb      (mant_c[0]),
        .guard    (guard_c),
        .sticky   (sticky_c),
        .round_up (rup_c)
    );

    // ---- stage p1: capture payload and rounding decision ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       vld_p1 <= 1'b0;
        else if (ready_p1) vld_p1 <= io.in_valid;
    end

    always_ff @(posedge clk) begin
        if (ready_p1 && io.in_valid) begin
            sign_p1 <= io.in_sign;
            exp_p1  <= io.in_exp;
            mant_p1 <= mant_c;
            rup_p1  <= rup_c;
            nx_p1   <= guard_c | sticky_c;
            ill_p1  <= illegal_c;
            zero_p1 <= io.in_zero;
            rm_p1   <= rm_eff_c;
            rd_p1   <= io.in_rd;
        end
    end

    assign wb_c = round_pack(sign_p1, exp_p1, mant_p1, rup_p1, nx_p1, rm_p1, zero_p1);

    // ---- stage p2: rounded result held for writeback ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p2    <= 1'b0;
            data_p2   <= '0;
            fflags_p2 <= '0;
            rd_p2     <= '0;
            ill_p2    <= 1'b0;
        end else if (ready_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2   <= wb_c.data;
                fflags_p2 <= wb_c.fflags;
                rd_p2     <= rd_p1;
                ill_p2    <= ill_p1;
            end
        end
    end

    assign io.out_valid   = vld_p2;
    assign io.out_data    = data_p2;
    assign io.out_fflags  = fflags_p2;
    assign io.out_rd      = rd_p2;
    assign io.out_illegal = ill_p2;

`ifdef FCVT_FFLAGS_ACC_EN
    // Clear has priority over an OR landing in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                       fflags_acc <= '0;
        else if (fflags_clr)               fflags_acc <= '0;
        else if (vld_p2 && io.out_ready)   fflags_acc <= fflags_acc | fflags_p2;
    end
`endif
endmodule
